nibble_serial_adder: RTL

// Multi-cycle wide adder front-end that sits directly upstream of a 4-bit ripple-carry adder slice.
// It captures WIDTH-bit operands through a valid/ready handshake and feeds the slice one nibble per cycle, LSB first.
// It registers the inter-nibble carry and assembles the full-width sum, carry-out and signed overflow.
// It delivers the result through an output valid/ready handshake. Used where a full-width combinational adder is too large or too slow.

---
 rtl/nibble_serial_adder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Multi-cycle WIDTH-bit adder that feeds a 4-bit slice one
//               nibble per cycle, LSB first, behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             ovf,
    output logic             busy
);

    localparam int c_NIB   = WIDTH / 4;
    localparam int c_CNT_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NIB - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;
    logic               r_ovf;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [c_CNT_W+1:0] w_base;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [4:0]         w_slice;

    assign w_accept = (r_state == c_IDLE) && in_valid;
    assign w_step   = (r_state == c_RUN);
    assign w_last   = (r_cnt == c_LAST);
    assign w_base   = {r_cnt, 2'b00};

    // The 4-bit ripple slice: current nibble pair plus the registered carry.
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];
    assign w_slice = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (in_valid)  w_next_state = c_RUN;
            c_RUN:   if (w_last)    w_next_state = c_DONE;
            c_DONE:  if (out_ready) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sum[w_base +: 4] <= w_slice[3:0];
            r_carry            <= w_slice[4];
            r_cnt              <= r_cnt + c_ONE;
            if (w_last) begin
                // Carry into the MSB (a^b^s) differs from carry out of it on overflow.
                r_carry_out <= w_slice[4];
                r_ovf       <= w_a_nib[3] ^ w_b_nib[3] ^ w_slice[3] ^ w_slice[4];
            end
        end
    end

    assign in_ready  = (r_state == c_IDLE);
    assign out_valid = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
